shift_arb: RTL and testbench
============================

# shift_arb

Round-robin arbiter and sequencer that shares one variable shift register datapath between two requesters. It accepts one shift request at a time over a valid/ready handshake and issues it to the shifter as a single enable pulse. It waits a fixed shifter latency, captures the result and returns it to the winning requester over a response handshake. It sits between the two client blocks and the shift datapath, and owns the shifter's enable, direction, amount and data inputs.

## Interface

**Parameters**
- `W`, 32: data width.
- `AW`, 6: shift amount width.
- `LAT`, 1: shifter latency in cycles, from the `sh_en` cycle to `sh_q` valid. Legal range 1..4.

**Ports**
- `clk` input 1: clock, rising edge.
- `clr` input 1: reset, synchronous, active-high.
- `req0_valid` input 1: requester 0 has a request.
- `req0_ready` output 1: requester 0 request accepted this cycle.
- `req0_dir` input 1: 0 = right shift, 1 = left shift.
- `req0_amt` input AW: shift amount.
- `req0_data` input W: shift-in data.
- `req1_valid`, `req1_ready`, `req1_dir`, `req1_amt`, `req1_data`: same as requester 0, for requester 1.
- `rsp0_valid` output 1: response pending for requester 0.
- `rsp0_ready` input 1: requester 0 takes the response.
- `rsp1_valid` output 1: response pending for requester 1.
- `rsp1_ready` input 1: requester 1 takes the response.
- `rsp_data` output W: result, shared by both responses.
- `rsp_err` output 1: request rejected; qualified by `rspN_valid`.
- `busy` output 1: state is not IDLE.
- `sh_en` output 1: shifter enable pulse.
- `sh_dir` output 1: shifter direction.
- `sh_amt` output AW: shifter amount.
- `sh_in` output W: shifter shift-in data.
- `sh_q` input W: shifter output.

## Operation

**States:** IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.

**IDLE**
- Grant goes to requester `rr` if its valid is high, else to the other requester if its valid is high.
- `reqN_ready` is combinational and high only for the granted requester.
- On grant: capture dir, amt and data; record the winner `gnt`; set `rr` to the other requester.
- If the amount is legal (0..32), go to ISSUE.
- If the amount is 33..63, see Configuration.

**ISSUE**
- One cycle only. `sh_en` = 1; `sh_dir`, `sh_amt` and `sh_in` carry the captured operands.
- Load the wait counter with LAT-1. Go to WAIT.

**WAIT**
- Decrement the counter each cycle.
- When the counter is 0: capture `sh_q` into `rsp_data`, clear `rsp_err`, go to RESP.

**RESP**
- `rsp<gnt>_valid` = 1, held until `rsp<gnt>_ready` is high.
- `rsp_data` and `rsp_err` stay stable for the whole RESP period.
- Handshake cycle: go to IDLE. No new grant is made in that same cycle.

**General rules**
- `sh_en` is 0 in every state except ISSUE.
- Outside ISSUE, `sh_dir`, `sh_amt` and `sh_in` hold their last values.
- A requester must hold valid and operands stable until it sees ready. Dropping valid before ready is legal; nothing is captured in that case.
- An amount of 0 is issued normally.

## Timing

- **Reset values:** all ready and valid outputs 0; `sh_en` 0; `busy` 0; `rsp_data` 0; `rsp_err` 0; `sh_dir`, `sh_amt`, `sh_in` 0; `rr` = 0; state IDLE.
- **Accept to response:** request accepted at edge T. `sh_en` is high in cycle T+1. `sh_q` is captured at the end of cycle T+1+LAT. `rsp_valid` rises in cycle T+2+LAT.
- **Back-to-back throughput:** one request per LAT+3 cycles when responses are taken immediately.
- **Simultaneous valid:** the requester selected by `rr` wins, then `rr` toggles. Requester 0 wins first after reset.
- **Reset mid-operation:** `clr` in any cycle forces IDLE and zeroes all outputs at the next edge. An in-flight response is discarded and no further `sh_en` pulse is issued.
- **Requests during busy:** ready stays 0 for both requesters until the cycle after the RESP handshake.

## Configuration

Macro `SHIFT_ARB_CLAMP_EN`:
- **Defined:** an amount of 33..63 is clamped to 32 at capture and executed normally; `rsp_err` = 0.
- **Undefined:** an amount of 33..63 goes from IDLE directly to RESP. No `sh_en` pulse is issued; `rsp_data` = 0; `rsp_err` = 1. The response rises one cycle after acceptance.

## Test plan

1. **Single request:** after reset, req0 with dir=0, amt=4, data=0x0000_00F0, LAT=1.
   - `req0_ready` is high at T.
   - `sh_en` is a single pulse at T+1 with `sh_amt`=4.
   - `rsp0_valid` rises at T+3 with `rsp_data` equal to `sh_q` at T+2 and `rsp_err`=0.
2. **Fairness:** req0 and req1 held valid continuously, responses taken immediately.
   - Grants alternate 0,1,0,1.
   - Each response goes only to its own requester.
3. **Response backpressure:** `rsp1_ready` held 0 for 5 cycles.
   - `rsp1_valid`, `rsp_data` and `rsp_err` stay stable.
   - `busy` stays 1 and no new ready is given.
   - After the handshake, IDLE follows and a grant is possible on the next cycle.
4. **Amount 40, macro undefined:** no `sh_en` pulse; response one cycle after accept with `rsp_err`=1 and `rsp_data`=0.
   - With the macro defined: `sh_amt`=32 and `rsp_err`=0.
5. **Reset during WAIT (LAT=3):** `clr` asserted while in WAIT.
   - All outputs are 0 at the next edge; no `rsp_valid` appears.
   - With req1 valid and req0 valid after reset, req0 is granted first.
6. **LAT=4, amt=0:** response at T+6; `rsp_data` equals the `sh_q` sampled at the end of cycle T+5.

Source files
------------

// File: rtl/shift_arb.sv
// shift_arb: round-robin arbiter and sequencer sharing one variable shifter between two requesters.
// Optional macro SHIFT_ARB_CLAMP_EN: clamp amounts above W to W instead of rejecting them.
module shift_arb #(
  parameter int W   = 32,
  parameter int AW  = 6,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_dir,
  input  logic [AW-1:0] req0_amt,
  input  logic [W-1:0]  req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_dir,
  input  logic [AW-1:0] req1_amt,
  input  logic [W-1:0]  req1_data,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_err,
  output logic          busy,
  output logic          sh_en,
  output logic          sh_dir,
  output logic [AW-1:0] sh_amt,
  output logic [W-1:0]  sh_in,
  input  logic [W-1:0]  sh_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [AW-1:0] AMT_MAX  = AW'(W);
  localparam logic [1:0]    CNT_LOAD = 2'(LAT - 1);

`ifdef SHIFT_ARB_CLAMP_EN
  localparam logic CLAMP_EN = 1'b1;
`else
  localparam logic CLAMP_EN = 1'b0;
`endif

  state_t        state_r, state_s;
  logic [1:0]    cnt_r;
  logic          rr_r, gnt_r;
  logic          gnt_s, grant_s, gnt_n_s, hs_s, amt_bad_s;
  logic          sel_dir_s;
  logic [AW-1:0] sel_amt_s, issue_amt_s;
  logic [W-1:0]  sel_data_s;
  logic          busy_r, sh_en_r, rsp0_valid_r, rsp1_valid_r, rsp_err_r, sh_dir_r;
  logic [AW-1:0] sh_amt_r;
  logic [W-1:0]  sh_in_r, rsp_data_r;

  // Round-robin grant in IDLE; nothing is granted while clr is high since it would be lost.
  always_comb begin
    gnt_s   = rr_r;
    grant_s = 1'b0;
    if (state_r == IDLE && !clr) begin
      if (rr_r ? req1_valid : req0_valid) begin
        gnt_s   = rr_r;
        grant_s = 1'b1;
      end else if (rr_r ? req0_valid : req1_valid) begin
        gnt_s   = ~rr_r;
        grant_s = 1'b1;
      end else begin
        gnt_s   = rr_r;
        grant_s = 1'b0;
      end
    end else begin
      gnt_s   = rr_r;
      grant_s = 1'b0;
    end
  end

  // Operand mux for the winner plus amount legality and the response handshake.
  always_comb begin
    sel_dir_s  = gnt_s ? req1_dir  : req0_dir;
    sel_amt_s  = gnt_s ? req1_amt  : req0_amt;
    sel_data_s = gnt_s ? req1_data : req0_data;
    amt_bad_s  = (sel_amt_s > AMT_MAX);
    if (amt_bad_s) begin
      issue_amt_s = AMT_MAX;
    end else begin
      issue_amt_s = sel_amt_s;
    end
    gnt_n_s = grant_s ? gnt_s : gnt_r;
    hs_s    = gnt_r ? rsp1_ready : rsp0_ready;
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          if (amt_bad_s && !CLAMP_EN) begin
            state_s = RESP;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (cnt_r == 2'd0) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, arbitration pointer, latency counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      rr_r         <= 1'b0;
      gnt_r        <= 1'b0;
      busy_r       <= 1'b0;
      sh_en_r      <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_data_r   <= '0;
      sh_dir_r     <= 1'b0;
      sh_amt_r     <= '0;
      sh_in_r      <= '0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != IDLE);
      sh_en_r      <= (state_s == ISSUE);
      rsp0_valid_r <= (state_s == RESP) && (gnt_n_s == 1'b0);
      rsp1_valid_r <= (state_s == RESP) && (gnt_n_s == 1'b1);
      if (grant_s) begin
        gnt_r <= gnt_s;
        rr_r  <= ~gnt_s;
      end
      // Shifter operands only move when a request is actually issued.
      if (grant_s && state_s == ISSUE) begin
        sh_dir_r <= sel_dir_s;
        sh_amt_r <= issue_amt_s;
        sh_in_r  <= sel_data_s;
      end
      if (grant_s && state_s == RESP) begin
        rsp_data_r <= '0;
        rsp_err_r  <= 1'b1;
      end
      if (state_r == ISSUE) begin
        cnt_r <= CNT_LOAD;
      end else if (state_r == WAIT && cnt_r != 2'd0) begin
        cnt_r <= cnt_r - 2'd1;
      end
      if (state_r == WAIT && cnt_r == 2'd0) begin
        rsp_data_r <= sh_q;
        rsp_err_r  <= 1'b0;
      end
    end
  end

  assign req0_ready = grant_s && (gnt_s == 1'b0);
  assign req1_ready = grant_s && (gnt_s == 1'b1);
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = busy_r;
  assign sh_en      = sh_en_r;
  assign sh_dir     = sh_dir_r;
  assign sh_amt     = sh_amt_r;
  assign sh_in      = sh_in_r;

endmodule

// File: tb/tb_shift_arb.sv
// Testbench for shift_arb: three instances with LAT = 1, 3, 4, each with its own shifter model
// and a transaction-level reference model; directed vectors, corner sequences and random traffic.
`timescale 1ns/1ps
module tb_shift_arb;
  localparam int W  = 32;
  localparam int AW = 6;
  localparam int NL = 3;
`ifdef SHIFT_ARB_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  logic          clr       [NL];
  logic          req_valid [NL][2];
  logic          req_ready [NL][2];
  logic          req_dir   [NL][2];
  logic [AW-1:0] req_amt   [NL][2];
  logic [W-1:0]  req_data  [NL][2];
  logic          rsp_valid [NL][2];
  logic          rsp_ready [NL][2];
  logic [W-1:0]  rsp_data  [NL];
  logic          rsp_err   [NL];
  logic          busy      [NL];
  logic          sh_en     [NL];
  logic          sh_dir    [NL];
  logic [AW-1:0] sh_amt    [NL];
  logic [W-1:0]  sh_in     [NL];

  function automatic logic [W-1:0] shf(logic d, int a, logic [W-1:0] x);
    if (a >= W) return '0;
    return d ? (x << a) : (x >> a);
  endfunction

  task automatic check(string name, int lane, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h at %0t", name, lane, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [W-1:0] pipe_d [4];
    logic         pipe_v [4];
    logic [W-1:0] junk;
    logic [W-1:0] q;

    shift_arb #(.W(W), .AW(AW), .LAT(L)) u_dut (
      .clk(clk), .clr(clr[g]),
      .req0_valid(req_valid[g][0]), .req0_ready(req_ready[g][0]), .req0_dir(req_dir[g][0]),
      .req0_amt(req_amt[g][0]), .req0_data(req_data[g][0]),
      .req1_valid(req_valid[g][1]), .req1_ready(req_ready[g][1]), .req1_dir(req_dir[g][1]),
      .req1_amt(req_amt[g][1]), .req1_data(req_data[g][1]),
      .rsp0_valid(rsp_valid[g][0]), .rsp0_ready(rsp_ready[g][0]),
      .rsp1_valid(rsp_valid[g][1]), .rsp1_ready(rsp_ready[g][1]),
      .rsp_data(rsp_data[g]), .rsp_err(rsp_err[g]), .busy(busy[g]),
      .sh_en(sh_en[g]), .sh_dir(sh_dir[g]), .sh_amt(sh_amt[g]), .sh_in(sh_in[g]), .sh_q(q)
    );

    // Shifter model: result valid exactly L cycles after sh_en, garbage at any other time.
    always @(posedge clk) begin
      junk      <= $urandom;
      pipe_v[0] <= sh_en[g] && !clr[g];
      pipe_d[0] <= shf(sh_dir[g], int'(sh_amt[g]), sh_in[g]);
      for (int i = 1; i < 4; i++) begin
        pipe_v[i] <= pipe_v[i-1] && !clr[g];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
    assign q = pipe_v[L-1] ? pipe_d[L-1] : junk;

    // Reference model: one transaction in flight, scheduled by cycle number from the accept cycle.
    int            cyc = 0, iss_at = -1, rsp_at = -1, own = 0, w = -1, a = 0;
    bit            mb = 1'b0, mrr = 1'b0, ld = 1'b0, re = 1'b0, ee = 1'b0, nd = 1'b0;
    logic [AW-1:0] la = '0, na = '0;
    logic [W-1:0]  li = '0, rd = '0, ed = '0, ni = '0;

    always @(negedge clk) begin
      if (run) begin
        cyc++;
        if (!mb) begin
          w = -1;
          if (clr[g]) w = -1;
          else if (req_valid[g][mrr]) w = int'(mrr);
          else if (req_valid[g][!mrr]) w = int'(!mrr);
          check("ready0", g, req_ready[g][0], w == 0);
          check("ready1", g, req_ready[g][1], w == 1);
          check("busy_idle", g, busy[g], 1'b0);
          check("sh_en_idle", g, sh_en[g], 1'b0);
          check("rsp0_idle", g, rsp_valid[g][0], 1'b0);
          check("rsp1_idle", g, rsp_valid[g][1], 1'b0);
          if (w >= 0) begin
            a   = int'(req_amt[g][w]);
            mb  = 1'b1;
            own = w;
            mrr = (w == 0);
            if (a > W && !CLAMP) begin
              iss_at = -1;
              rsp_at = cyc + 1;
              ed     = '0;
              ee     = 1'b1;
            end else begin
              if (a > W) a = W;
              iss_at = cyc + 1;
              rsp_at = cyc + 2 + L;
              ed     = shf(req_dir[g][w], a, req_data[g][w]);
              ee     = 1'b0;
              nd     = req_dir[g][w];
              na     = AW'(a);
              ni     = req_data[g][w];
            end
          end
        end else begin
          check("ready0_busy", g, req_ready[g][0], 1'b0);
          check("ready1_busy", g, req_ready[g][1], 1'b0);
          check("busy", g, busy[g], 1'b1);
          check("sh_en", g, sh_en[g], cyc == iss_at);
          if (cyc == iss_at) begin
            ld = nd;
            la = na;
            li = ni;
          end
          if (cyc == rsp_at) begin
            rd = ed;
            re = ee;
          end
          check("rsp0_valid", g, rsp_valid[g][0], (cyc >= rsp_at) && own == 0);
          check("rsp1_valid", g, rsp_valid[g][1], (cyc >= rsp_at) && own == 1);
          if (cyc >= rsp_at && rsp_ready[g][own]) mb = 1'b0;
        end
        check("sh_dir", g, sh_dir[g], ld);
        check("sh_amt", g, sh_amt[g], la);
        check("sh_in", g, sh_in[g], li);
        check("rsp_data", g, rsp_data[g], rd);
        check("rsp_err", g, rsp_err[g], re);
        if (clr[g]) begin
          mb = 1'b0; mrr = 1'b0; ld = 1'b0; la = '0; li = '0; rd = '0; re = 1'b0;
        end
      end
    end
  end

  typedef struct {
    int            lane;
    int            rq;
    logic          dir;
    logic [AW-1:0] amt;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_data;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k, input int r, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = req_ready[k][r];
    end
    check(name, k, seen, 1'b1);
  endtask

  task automatic apply_vec(input vec_t v);
    int n = 0;
    bit seen = 1'b0;
    tick();
    rsp_ready[v.lane][v.rq] = 1'b1;
    req_valid[v.lane][v.rq] = 1'b1;
    req_dir[v.lane][v.rq]   = v.dir;
    req_amt[v.lane][v.rq]   = v.amt;
    req_data[v.lane][v.rq]  = v.data;
    wait_ready(v.lane, v.rq, "vec_grant");
    tick();
    req_valid[v.lane][v.rq] = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      seen = rsp_valid[v.lane][v.rq];
    end
    check("vec_latency", v.lane, n, v.exp_lat);
    check("vec_data", v.lane, rsp_data[v.lane], v.exp_data);
    check("vec_err", v.lane, rsp_err[v.lane], v.exp_err);
    tick();
    rsp_ready[v.lane][v.rq] = 1'b0;
  endtask

  initial begin
    int n, w;
    bit seen_rdy [NL][2];

    vt[0] = '{0, 0, 1'b0, 6'd4,  32'h0000_00F0, 32'h0000_000F, 1'b0, 3};
    vt[1] = '{0, 1, 1'b1, 6'd8,  32'h0000_00AB, 32'h0000_AB00, 1'b0, 3};
    vt[2] = '{0, 0, 1'b1, 6'd0,  32'h1234_5678, 32'h1234_5678, 1'b0, 3};
    vt[3] = '{0, 1, 1'b0, 6'd32, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3};
    vt[4] = '{0, 0, 1'b1, 6'd31, 32'h0000_0003, 32'h8000_0000, 1'b0, 3};
`ifdef SHIFT_ARB_CLAMP_EN
    vt[5] = '{0, 1, 1'b1, 6'd40, 32'h0000_0055, 32'h0000_0000, 1'b0, 3};
`else
    vt[5] = '{0, 1, 1'b1, 6'd40, 32'h0000_0055, 32'h0000_0000, 1'b1, 1};
`endif
    vt[6] = '{2, 1, 1'b0, 6'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 6};
    vt[7] = '{1, 0, 1'b0, 6'd16, 32'hCAFE_0000, 32'h0000_CAFE, 1'b0, 5};

    for (int k = 0; k < NL; k++) begin
      clr[k] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        req_valid[k][r] = 1'b0; req_dir[k][r] = 1'b0; req_amt[k][r] = '0;
        req_data[k][r]  = '0;   rsp_ready[k][r] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NL; k++) clr[k] = 1'b0;
    run = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(vt[i]);

    // Fairness and throughput on lane 0 after a fresh reset.
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      rsp_ready[0][r] = 1'b1; req_valid[0][r] = 1'b1; req_dir[0][r] = 1'(r);
      req_amt[0][r] = 6'd1;   req_data[0][r] = 32'h0000_0100 + r;
    end
    for (int i = 0; i < 4; i++) begin
      n = 0; w = -1;
      while (n < 20 && w < 0) begin
        @(negedge clk);
        n++;
        if (req_ready[0][0]) w = 0;
        else if (req_ready[0][1]) w = 1;
      end
      check("fair_grant", 0, w, i % 2);
      if (i > 0) check("fair_spacing", 0, n, 4);
    end
    tick();
    req_valid[0][0] = 1'b0; req_valid[0][1] = 1'b0;
    repeat (8) tick();

    // Response backpressure on requester 1 with requester 0 waiting.
    rsp_ready[0][1] = 1'b0;
    req_valid[0][1] = 1'b1; req_dir[0][1] = 1'b1; req_amt[0][1] = 6'd3; req_data[0][1] = 32'h0F0F_0001;
    wait_ready(0, 1, "bp_grant");
    tick();
    req_valid[0][1] = 1'b0;
    req_valid[0][0] = 1'b1; req_dir[0][0] = 1'b0; req_amt[0][0] = 6'd2; req_data[0][0] = 32'h0000_0040;
    n = 0;
    while (n < 20 && !rsp_valid[0][1]) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", 0, rsp_valid[0][1], 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 0, rsp_valid[0][1], 1'b1);
      check("bp_data", 0, rsp_data[0], 32'h7878_0008);
      check("bp_err", 0, rsp_err[0], 1'b0);
      check("bp_busy", 0, busy[0], 1'b1);
      check("bp_no_ready", 0, req_ready[0][0], 1'b0);
    end
    tick();
    rsp_ready[0][1] = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 0, rsp_valid[0][1], 1'b1);
    tick();
    rsp_ready[0][1] = 1'b0;
    @(negedge clk);
    check("bp_after_busy", 0, busy[0], 1'b0);
    check("bp_after_grant", 0, req_ready[0][0], 1'b1);
    tick();
    req_valid[0][0] = 1'b0;
    repeat (8) tick();

    // Reset while lane 1 (LAT=3) is in WAIT.
    rsp_ready[1][0] = 1'b1; rsp_ready[1][1] = 1'b1;
    req_valid[1][0] = 1'b1; req_dir[1][0] = 1'b0; req_amt[1][0] = 6'd4; req_data[1][0] = 32'hFFFF_0000;
    wait_ready(1, 0, "rst_grant");
    tick();
    req_valid[1][0] = 1'b0;
    tick();
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    @(negedge clk);
    check("rst_busy", 1, busy[1], 1'b0);
    check("rst_sh_en", 1, sh_en[1], 1'b0);
    check("rst_rsp0", 1, rsp_valid[1][0], 1'b0);
    check("rst_rsp1", 1, rsp_valid[1][1], 1'b0);
    check("rst_rsp_data", 1, rsp_data[1], 32'h0);
    check("rst_rsp_err", 1, rsp_err[1], 1'b0);
    check("rst_sh_dir", 1, sh_dir[1], 1'b0);
    check("rst_sh_amt", 1, sh_amt[1], 6'd0);
    check("rst_sh_in", 1, sh_in[1], 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_rsp", 1, rsp_valid[1][0], 1'b0);
      check("rst_no_en", 1, sh_en[1], 1'b0);
    end
    tick();
    req_valid[1][0] = 1'b1; req_valid[1][1] = 1'b1;
    req_amt[1][1] = 6'd1; req_data[1][1] = 32'h0000_0002;
    @(negedge clk);
    check("rst_first_r0", 1, req_ready[1][0], 1'b1);
    check("rst_first_r1", 1, req_ready[1][1], 1'b0);
    tick();
    req_valid[1][0] = 1'b0;
    wait_ready(1, 1, "rst_second");
    tick();
    req_valid[1][1] = 1'b0;
    repeat (10) tick();

    // Random traffic on all lanes, including occasional resets and dropped requests.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NL; k++)
        for (int r = 0; r < 2; r++) seen_rdy[k][r] = req_valid[k][r] && req_ready[k][r];
      tick();
      for (int k = 0; k < NL; k++) begin
        clr[k] = ($urandom_range(0, 299) == 0);
        for (int r = 0; r < 2; r++) begin
          rsp_ready[k][r] = ($urandom_range(0, 3) != 0);
          if (!req_valid[k][r] || seen_rdy[k][r]) begin
            req_valid[k][r] = ($urandom_range(0, 2) != 0);
            req_dir[k][r]   = 1'($urandom_range(0, 1));
            req_amt[k][r]   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(33, 63))
                                                          : 6'($urandom_range(0, 32));
            req_data[k][r]  = $urandom;
          end else if ($urandom_range(0, 19) == 0) begin
            req_valid[k][r] = 1'b0;
          end
        end
      end
    end
    for (int k = 0; k < NL; k++) begin
      clr[k] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        req_valid[k][r] = 1'b0;
        rsp_ready[k][r] = 1'b1;
      end
    end
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
